// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated two-approach phase scheduler with optional pedestrian walk.
// Define TRAFFIC_PED_EN to build the pedestrian logic, PED_WALK and register 5.
module traffic_phase_scheduler #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             req_ped,
  output logic [2:0]       lights_a,
  output logic [2:0]       lights_b,
  output logic             walk,
  output logic             ped_ack,
  output logic [3:0]       phase
);

`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RED_A    = 4'd1,
    PREP_A   = 4'd2,
    GREEN_A  = 4'd3,
    CLEAR_A  = 4'd4,
    RED_B    = 4'd5,
    PREP_B   = 4'd6,
    GREEN_B  = 4'd7,
    CLEAR_B  = 4'd8,
    PED_WALK = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_elapsed;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_effmax;
  logic [CNT_W-1:0] r_t_red;
  logic [CNT_W-1:0] r_t_prep;
  logic [CNT_W-1:0] r_t_min;
  logic [CNT_W-1:0] r_t_max;
  logic [CNT_W-1:0] r_t_clr;
  logic [CNT_W-1:0] r_t_walk;
  logic             r_ped_pend;
  logic             r_ped_b;

  logic             w_tick;
  logic             w_done;
  logic             w_gend;
  logic             w_other;
  logic             w_entry;
  logic [CNT_W-1:0] w_el_nx;
  logic [CNT_W-1:0] w_dur;
  logic [CNT_W-1:0] w_load;
  logic [CNT_W-1:0] w_mx;
  logic [CNT_W-1:0] w_effmax;

  function automatic logic [5:0] f_lamps(state_t s);
    case (s)
      PREP_A, CLEAR_A: f_lamps = 6'b010_001;
      GREEN_A:         f_lamps = 6'b100_001;
      PREP_B, CLEAR_B: f_lamps = 6'b001_010;
      GREEN_B:         f_lamps = 6'b001_100;
      default:         f_lamps = 6'b001_001;
    endcase
  endfunction

  assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
  assign w_done   = w_tick && (r_timer == CNT_W'(1));
  assign w_el_nx  = (w_tick && r_elapsed != '1) ? r_elapsed + 1'b1 : r_elapsed;
  assign w_other  = (r_state == GREEN_A) ? req_b : req_a;
  assign w_gend   = !enable || (w_el_nx >= r_effmax) ||
                    ((w_el_nx >= r_min) && (w_other || r_ped_pend));
  assign w_entry  = (w_next != r_state);
  assign w_load   = (w_dur == '0) ? CNT_W'(1) : w_dur;
  assign w_mx     = (r_t_max > r_t_min) ? r_t_max : r_t_min;
  assign w_effmax = (w_mx == '0) ? CNT_W'(1) : w_mx;
  assign phase    = r_state;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (enable) w_next = RED_A;
      RED_A:    if (w_done) w_next = enable ? PREP_A : IDLE;
      PREP_A:   if (w_done) w_next = enable ? GREEN_A : CLEAR_A;
      GREEN_A:  if (w_gend) w_next = CLEAR_A;
      CLEAR_A:  if (w_done) w_next = !enable ? IDLE :
                                     r_ped_pend ? PED_WALK : RED_B;
      RED_B:    if (w_done) w_next = enable ? PREP_B : IDLE;
      PREP_B:   if (w_done) w_next = enable ? GREEN_B : CLEAR_B;
      GREEN_B:  if (w_gend) w_next = CLEAR_B;
      CLEAR_B:  if (w_done) w_next = !enable ? IDLE :
                                     r_ped_pend ? PED_WALK : RED_A;
      PED_WALK: if (w_done) w_next = !enable ? IDLE :
                                     r_ped_b ? RED_A : RED_B;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_dur = r_t_red;
    case (w_next)
      PREP_A, PREP_B:   w_dur = r_t_prep;
      CLEAR_A, CLEAR_B: w_dur = r_t_clr;
      PED_WALK:         w_dur = r_t_walk;
      default:          w_dur = r_t_red;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_presc    <= '0;
      r_timer    <= '0;
      r_elapsed  <= '0;
      r_min      <= '0;
      r_effmax   <= CNT_W'(1);
      r_t_red    <= CNT_W'(2);
      r_t_prep   <= CNT_W'(1);
      r_t_min    <= CNT_W'(4);
      r_t_max    <= CNT_W'(10);
      r_t_clr    <= CNT_W'(2);
      r_t_walk   <= CNT_W'(5);
      r_ped_pend <= 1'b0;
      r_ped_b    <= 1'b0;
      lights_a   <= 3'b001;
      lights_b   <= 3'b001;
      walk       <= 1'b0;
      ped_ack    <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          3'd0:    r_t_red  <= cfg_wdata;
          3'd1:    r_t_prep <= cfg_wdata;
          3'd2:    r_t_min  <= cfg_wdata;
          3'd3:    r_t_max  <= cfg_wdata;
          3'd4:    r_t_clr  <= cfg_wdata;
          3'd5:    if (PED_EN) r_t_walk <= cfg_wdata;
          default: ;
        endcase
      end
      if (w_entry) begin
        r_state   <= w_next;
        r_presc   <= '0;
        r_timer   <= w_load;
        r_elapsed <= '0;
        r_min     <= r_t_min;
        r_effmax  <= w_effmax;
      end else begin
        r_presc   <= w_tick ? '0 : r_presc + 1'b1;
        r_elapsed <= w_el_nx;
        if (w_tick && r_timer != '0)
          r_timer <= r_timer - 1'b1;
      end
      // walk entry acknowledges the request; presses during the walk are dropped
      if (w_entry && w_next == PED_WALK) begin
        r_ped_pend <= 1'b0;
        r_ped_b    <= (r_state == CLEAR_B);
      end else if (PED_EN && req_ped && r_state != PED_WALK) begin
        r_ped_pend <= 1'b1;
      end
      {lights_a, lights_b} <= f_lamps(w_next);
      walk    <= (w_next == PED_WALK);
      ped_ack <= w_entry && (w_next == PED_WALK);
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with TICK_DIV=4.
module tb_traffic_phase_scheduler;
  localparam int CNT_W = 8;
  localparam logic [3:0] P_IDLE = 4'd0, P_RA = 4'd1, P_PA = 4'd2,
    P_GA = 4'd3, P_CA = 4'd4, P_RB = 4'd5, P_PB = 4'd6, P_GB = 4'd7,
    P_CB = 4'd8, P_PW = 4'd9;

  logic clk = 1'b0;
  logic rst, enable, cfg_we, req_a, req_b, req_ped;
  logic [2:0] cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic [2:0] lights_a, lights_b;
  logic walk, ped_ack;
  logic [3:0] phase;
  int n_chk = 0;
  int n_err = 0;

  traffic_phase_scheduler #(.TICK_DIV(4), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .req_a(req_a), .req_b(req_b), .req_ped(req_ped),
    .lights_a(lights_a), .lights_b(lights_b),
    .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic measure(output int n);
    logic [3:0] p0;
    p0 = phase;
    n = 0;
    while (phase == p0 && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic pchk(string tag, logic [3:0] p, logic [5:0] lmp, int len);
    int n;
    chk({tag, "_ph"}, phase, p);
    chk({tag, "_lmp"}, {lights_a, lights_b}, lmp);
    measure(n);
    chk({tag, "_len"}, n, len);
  endtask

  task automatic wait_ph(string tag, logic [3:0] p);
    int n;
    n = 0;
    while (phase != p && n < 1000) begin
      n++;
      step();
    end
    chk({tag, "_reach"}, phase, p);
  endtask

  task automatic wr(logic [2:0] a, logic [CNT_W-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; req_a = 1'b0; req_b = 1'b0; req_ped = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_ph", phase, P_IDLE);
    chk("rst_lmp", {lights_a, lights_b}, 6'b001001);
    chk("rst_walk", walk, 0);
    chk("rst_ack", ped_ack, 0);

    // default timing walk-through
    enable = 1'b1;
    step();
    pchk("t1_ra", P_RA, 6'b001001, 8);
    pchk("t1_pa", P_PA, 6'b010001, 4);
    pchk("t1_ga", P_GA, 6'b100001, 40);
    pchk("t1_ca", P_CA, 6'b010001, 8);
    pchk("t1_rb", P_RB, 6'b001001, 8);
    pchk("t1_pb", P_PB, 6'b001010, 4);
    pchk("t1_gb", P_GB, 6'b001100, 40);
    pchk("t1_cb", P_CB, 6'b001010, 8);

    // demand from B cuts green A at min
    pchk("t2_ra", P_RA, 6'b001001, 8);
    pchk("t2_pa", P_PA, 6'b010001, 4);
    chk("t2_ga_ph", phase, P_GA);
    repeat (6) step();
    req_b = 1'b1;
    measure(n);
    req_b = 1'b0;
    chk("t2_ga_len", n + 6, 16);

    // T_PREP=0, min 7 above max 3
    chk("t3_ca_ph", phase, P_CA);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd7);
    wr(3'd3, 8'd3);
    wr(3'd6, 8'd0);
    measure(n);
    chk("t3_ca_len", n + 4, 8);
    pchk("t3_rb", P_RB, 6'b001001, 8);
    pchk("t3_pb", P_PB, 6'b001010, 4);
    pchk("t3_gb", P_GB, 6'b001100, 28);
    chk("t3_cb_ph", phase, P_CB);
    wr(3'd1, 8'd2);
    wr(3'd2, 8'd2);
    wr(3'd3, 8'd10);
    measure(n);
    chk("t3_cb_len", n + 3, 8);

    // pedestrian request during green B
    pchk("t4_ra", P_RA, 6'b001001, 8);
    pchk("t4_pa", P_PA, 6'b010001, 8);
    pchk("t4_ga", P_GA, 6'b100001, 40);
    pchk("t4_ca", P_CA, 6'b010001, 8);
    pchk("t4_rb", P_RB, 6'b001001, 8);
    pchk("t4_pb", P_PB, 6'b001010, 8);
    chk("t4_gb_ph", phase, P_GB);
    req_ped = 1'b1;
    step();
    req_ped = 1'b0;
    measure(n);
`ifdef TRAFFIC_PED_EN
    chk("t4_gb_len", n + 1, 8);
    pchk("t4_cb", P_CB, 6'b001010, 8);
    chk("t4_pw_ph", phase, P_PW);
    chk("t4_pw_ack", ped_ack, 1);
    chk("t4_pw_walk", walk, 1);
    chk("t4_pw_lmp", {lights_a, lights_b}, 6'b001001);
    step();
    chk("t4_ack_pulse", ped_ack, 0);
    measure(n);
    chk("t4_pw_len", n + 1, 20);
    chk("t4_walk_off", walk, 0);
`else
    chk("t4_gb_len", n + 1, 40);
    pchk("t4_cb", P_CB, 6'b001010, 8);
    chk("t4_walk", walk, 0);
    chk("t4_ack", ped_ack, 0);
`endif

    // enable drop in green A
    pchk("t5_ra", P_RA, 6'b001001, 8);
    pchk("t5_pa", P_PA, 6'b010001, 8);
    chk("t5_ga_ph", phase, P_GA);
    step(); step();
    enable = 1'b0;
    step();
    pchk("t5_ca", P_CA, 6'b010001, 8);
    chk("t5_idle_ph", phase, P_IDLE);
    chk("t5_idle_lmp", {lights_a, lights_b}, 6'b001001);
    repeat (5) step();
    chk("t5_idle_hold", phase, P_IDLE);
    enable = 1'b1;
    step();
    chk("t5_re_ph", phase, P_RA);

    // reset mid PREP_B restores defaults
    wait_ph("t6_pb", P_PB);
    step();
    rst = 1'b1;
    step();
    chk("t6_ph", phase, P_IDLE);
    chk("t6_lmp", {lights_a, lights_b}, 6'b001001);
    rst = 1'b0;
    req_b = 1'b1;
    step();
    pchk("t6_ra", P_RA, 6'b001001, 8);
    pchk("t6_pa", P_PA, 6'b010001, 4);
    pchk("t6_ga", P_GA, 6'b100001, 16);
    req_b = 1'b0;
    pchk("t6_ca", P_CA, 6'b010001, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
